// File: rtl/alu_issue_stage_if.sv
// Issue and writeback handshake bundle for the ALU issue stage.
// The master drives issue requests and consumes results. The slave is the stage itself.
interface alu_issue_stage_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [3:0]   in_rd;
    logic         in_setf;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic [3:0]   out_flags;
    logic [3:0]   out_rd;
    logic         out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, in_setf, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_rd, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, in_setf, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_rd, out_err
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute-stage wrapper around a parallel-result ALU.
// Operands are registered, the stage waits out multicycle paths, selects a result and holds it for writeback.
module alu_issue_stage #(
    parameter int N          = 32,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_stage_if.slave bus,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    input  logic [N-1:0]     alu_rs,
    input  logic [N-1:0]     alu_rr,
    input  logic [N-1:0]     alu_rm,
    input  logic [N-1:0]     alu_rd,
    input  logic [N-1:0]     alu_rmod,
    input  logic [N-1:0]     alu_rmov,
    input  logic [3:0]       alu_fs,
    input  logic [3:0]       alu_fr,
    input  logic [3:0]       alu_fm,
    input  logic [3:0]       alu_fd,
    input  logic [3:0]       alu_fmod,
    input  logic [3:0]       alu_fmov,
    output logic [3:0]       flags_q
);
    localparam int MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_L + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   load_cnt;
    logic [2:0]         op_reg;
    logic [3:0]         rd_reg;
    logic               setf_reg;
    logic               accept;
    logic               capture;
    logic               legal;
    logic [N-1:0]       sel_result;
    logic [3:0]         sel_flags;
    logic [N-1:0]       out_result_reg;
    logic [3:0]         out_flags_reg;
    logic [3:0]         out_rd_reg;
    logic               out_err_reg;

    // Count preload is L-1 so the capture lands exactly L edges after accept.
    always_comb begin
        load_cnt = '0;
        case (bus.in_op)
            3'b010:         load_cnt = CNT_W'(MUL_CYCLES - 1);
            3'b011, 3'b100: load_cnt = CNT_W'(DIV_CYCLES - 1);
            default:        load_cnt = '0;
        endcase
    end

    assign legal = (op_reg <= 3'd5);

    always_comb begin
        sel_result = '0;
        sel_flags  = '0;
        case (op_reg)
            3'd0: begin sel_result = alu_rs;   sel_flags = alu_fs;   end
            3'd1: begin sel_result = alu_rr;   sel_flags = alu_fr;   end
            3'd2: begin sel_result = alu_rm;   sel_flags = alu_fm;   end
            3'd3: begin sel_result = alu_rd;   sel_flags = alu_fd;   end
            3'd4: begin sel_result = alu_rmod; sel_flags = alu_fmod; end
            3'd5: begin sel_result = alu_rmov; sel_flags = alu_fmov; end
            default: begin sel_result = '0;    sel_flags = '0;       end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            op_reg         <= '0;
            rd_reg         <= '0;
            setf_reg       <= 1'b0;
            alu_a          <= '0;
            alu_b          <= '0;
            out_result_reg <= '0;
            out_flags_reg  <= '0;
            out_rd_reg     <= '0;
            out_err_reg    <= 1'b0;
            flags_q        <= '0;
        end else begin
            if (accept) begin
                alu_a    <= bus.in_a;
                alu_b    <= bus.in_b;
                op_reg   <= bus.in_op;
                rd_reg   <= bus.in_rd;
                setf_reg <= bus.in_setf;
                cnt_reg  <= load_cnt;
            end else if (state_reg == WAIT && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
            if (capture) begin
                out_result_reg <= sel_result;
                out_flags_reg  <= sel_flags;
                out_rd_reg     <= rd_reg;
                out_err_reg    <= ~legal;
                if (setf_reg && legal) begin
                    flags_q <= sel_flags;
                end
            end
        end
    end

    assign bus.in_ready   = (state_reg == IDLE);
    assign bus.out_valid  = (state_reg == HOLD);
    assign bus.out_result = out_result_reg;
    assign bus.out_flags  = out_flags_reg;
    assign bus.out_rd     = out_rd_reg;
    assign bus.out_err    = out_err_reg;
endmodule
